mux_scan_sampler: RTL and testbench
===================================

Name: mux_scan_sampler

Overview:
- Upstream controller for the 4:1 mux (x1..x4, selects s1/s2, output f).
- Steps the mux through all four channels in order and waits a programmable settle time after each select change.
- Samples f for each channel and packs the four samples into a 4-bit word.
- Presents the word to a downstream consumer over a valid/ready handshake, as a single-shot scan or continuously.

Parameters:
- SETTLE_CYCLES, 2, cycles the select is held stable before f is sampled; legal range 1..255, 0 is illegal (elaboration assertion).
- CNT_W, 8, settle counter width; must satisfy SETTLE_CYCLES <= 2**CNT_W - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- continuous  in  1  when 1, the block rescans automatically after each accepted word; sampled at handshake.
- s1  out  1  mux select LSB, registered.
- s2  out  1  mux select MSB, registered.
- f  in  1  mux output.
- word  out  4  packed samples; bit i = f sampled with channel i selected.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Channel map:
  - ch = {s2,s1}.
  - 00 selects x1, 01 selects x2, 10 selects x3, 11 selects x4.
  - word[0]=x1, word[1]=x2, word[2]=x3, word[3]=x4.
- Reset (async, immediate):
  - state=IDLE; s1=s2=0; word=4'b0000; word_valid=0; busy=0.
  - Settle counter and channel index cleared.
  - Reset mid-scan discards any partial word.
- States are IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - start=1 -> SETTLE, ch=0, cnt=0.
  - Otherwise stay.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 -> SAMPLE.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - shadow[ch] <= f.
  - ch<3 -> ch+1, cnt=0, SETTLE.
  - ch==3 -> HOLD; word <= full shadow including this sample; word_valid=1.
- HOLD:
  - word and word_valid stay stable until word_ready=1.
  - On handshake, word_valid drops next cycle.
  - continuous=1 -> SETTLE with ch=0; continuous=0 -> IDLE.
- Select timing:
  - s1/s2 update on the same edge the channel index changes.
  - The select is stable for every SETTLE cycle and the SAMPLE cycle.
- Latency:
  - word_valid rises 4*(SETTLE_CYCLES+1) cycles after the edge that accepts start.
  - With the default, that is 12 cycles.
- Boundary conditions:
  - start outside IDLE is ignored; no queuing.
  - word_ready without word_valid has no effect.
  - word_ready held high in HOLD gives a 1-cycle hold.
  - Changing continuous mid-scan only matters at the handshake.
  - The word register is updated only when entering HOLD; it keeps its last value in IDLE.
  - busy=0 exactly in IDLE.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output word_parity (1 bit) = even parity (XOR) of word.
  - Registered alongside word; reset 0.
  - Valid whenever word_valid=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - NUM_CH=4, CH_W=2.
  - State enum scan_state_t {IDLE, SETTLE, SAMPLE, HOLD}.
  - Helper function ch_to_sel(ch) returning {s2,s1}.
- One sub-module, settle_timer:
  - Load/count/done interface.
  - Parameterised by SETTLE_CYCLES and CNT_W.
  - Instantiated once.
- FSM, channel index and shadow register live in the top.

Test Plan:
- Reset: rst=1 mid-SETTLE at ch=2 -> immediately s1=s2=0, word_valid=0, busy=0, word=0; after release the block stays IDLE until start.
- Single scan: behavioural mux with x1..x4=1,0,1,1, start pulse, continuous=0, word_ready=1 -> word_valid at cycle 12, word=4'b1101, returns to IDLE, busy=0.
- Select sequence: SETTLE_CYCLES=3 -> {s2,s1} = 00,01,10,11, each held 4 cycles; word_valid at cycle 16.
- Backpressure: word_ready=0 for 7 cycles in HOLD -> word and word_valid stable throughout; x inputs changed meanwhile do not alter word; one-cycle accept on ready.
- Continuous: continuous=1, ready always 1, inputs changed between scans 0000 -> 1010 -> words 4'b0000 then 4'b0101, back-to-back with 12 cycles between valids (plus 1 HOLD cycle); start pulses during scanning ignored.
- Parity (MUX_SCAN_PARITY_EN): word=4'b1101 -> word_parity=1; word=4'b0101 -> word_parity=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types, sizes and helpers for the 4:1 mux scan sampler.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  // Channel index maps straight onto {s2,s1}: 00->x1, 01->x2, 10->x3, 11->x4.
  function automatic logic [CH_W-1:0] ch_to_sel(input logic [CH_W-1:0] ch);
    return {ch[1], ch[0]};
  endfunction

  function automatic logic even_parity(input logic [NUM_CH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mux_scan_sampler_settle_timer.sv
// Settle-time counter: load clears, count advances, done marks the last settle cycle.
// Also holds the elaboration-time parameter checker for the timer.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == CNT_LAST);

  // Settle counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_count && !w_done) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = w_done;

endmodule

module settle_timer_param_chk #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) ();

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("settle_timer: SETTLE_CYCLES=%0d outside 1..255", SETTLE_CYCLES);
  end

  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("settle_timer: CNT_W=%0d outside 1..30", CNT_W);
  end else if (SETTLE_CYCLES > (2 ** CNT_W) - 1) begin : g_cnt_too_narrow
    $error("settle_timer: CNT_W=%0d too narrow for SETTLE_CYCLES=%0d", CNT_W, SETTLE_CYCLES);
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux through x1..x4, samples f after a settle time, and offers the packed word on valid/ready.
// Optional word_parity output when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_continuous,
  output logic       o_s1,
  output logic       o_s2,
  input  logic       i_f,
  output logic [3:0] o_word,
  output logic       o_word_valid,
  input  logic       i_word_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic       o_word_parity,
`endif
  output logic       o_busy
);

  localparam logic [CH_W-1:0] CH_FIRST = CH_W'(0);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] w_shadow_nxt;
  logic [CH_W-1:0]   r_sel;
  logic [3:0]        r_word;
  logic              r_word_valid;
  logic              r_busy;
  logic              w_load;
  logic              w_count;
  logic              w_done;
  logic              w_word_load;
  logic              w_accept;

  settle_timer_param_chk #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_param_chk ();

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_count (w_count),
    .o_done  (w_done)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch;
    w_shadow_nxt = r_shadow;
    w_load       = 1'b0;
    w_count      = 1'b0;
    w_word_load  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = SETTLE;
          w_ch_nxt    = CH_FIRST;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (w_done) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_count = 1'b1;
        end
      end
      SAMPLE: begin
        w_shadow_nxt[r_ch] = i_f;
        if (r_ch == CH_LAST) begin
          w_state_nxt = HOLD;
          w_word_load = 1'b1;
        end else begin
          w_state_nxt = SETTLE;
          w_ch_nxt    = r_ch + CH_ONE;
          w_load      = 1'b1;
        end
      end
      HOLD: begin
        if (i_word_ready) begin
          w_accept = 1'b1;
          if (i_continuous) begin
            w_state_nxt = SETTLE;
            w_ch_nxt    = CH_FIRST;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Channel index, shadow samples and select lines; select moves on the same edge as the index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ch     <= CH_FIRST;
      r_shadow <= {NUM_CH{1'b0}};
      r_sel    <= {CH_W{1'b0}};
    end else begin
      r_ch     <= w_ch_nxt;
      r_shadow <= w_shadow_nxt;
      r_sel    <= ch_to_sel(w_ch_nxt);
    end
  end

  // Output word, handshake valid and busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word       <= 4'b0000;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_word_load) begin
        r_word <= w_shadow_nxt;
      end else begin
        r_word <= r_word;
      end
      if (w_word_load) begin
        r_word_valid <= 1'b1;
      end else if (w_accept) begin
        r_word_valid <= 1'b0;
      end else begin
        r_word_valid <= r_word_valid;
      end
      r_busy <= (w_state_nxt != IDLE);
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_word_parity;

  // Parity is captured together with the word so both change on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word_parity <= 1'b0;
    end else if (w_word_load) begin
      r_word_parity <= even_parity(w_shadow_nxt);
    end else begin
      r_word_parity <= r_word_parity;
    end
  end

  assign o_word_parity = r_word_parity;
`endif

  assign o_s1         = r_sel[0];
  assign o_s2         = r_sel[1];
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed and randomized bench for mux_scan_sampler against a behavioural 4:1 mux.
// Parity checks are active when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, cont, ready, s1, s2, f, valid, busy;
  logic [3:0] word, x;
  logic       start3, ready3, s1_3, s2_3, f3, valid3, busy3;
  logic [3:0] word3, x3;
`ifdef MUX_SCAN_PARITY_EN
  logic       par, par3;
`endif

  // Behavioural mux: x is held in word order, x[0]=x1 .. x[3]=x4.
  assign f  = x[{s2, s1}];
  assign f3 = x3[{s2_3, s1_3}];

  mux_scan_sampler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_continuous (cont),
    .o_s1         (s1),
    .o_s2         (s2),
    .i_f          (f),
    .o_word       (word),
    .o_word_valid (valid),
    .i_word_ready (ready),
`ifdef MUX_SCAN_PARITY_EN
    .o_word_parity(par),
`endif
    .o_busy       (busy)
  );

  mux_scan_sampler #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start3),
    .i_continuous (1'b0),
    .o_s1         (s1_3),
    .o_s2         (s2_3),
    .i_f          (f3),
    .o_word       (word3),
    .o_word_valid (valid3),
    .i_word_ready (ready3),
`ifdef MUX_SCAN_PARITY_EN
    .o_word_parity(par3),
`endif
    .o_busy       (busy3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for word_valid (bounded), optionally poking start while the scan runs.
  task automatic wait_valid(input int poke, output int n, output logic busy_all);
    n        = 0;
    busy_all = 1'b1;
    while (!valid && n < 200) begin
      start = (n == poke) ? 1'b1 : 1'b0;
      tick();
      n++;
      busy_all = busy_all & busy;
    end
    start = 1'b0;
  endtask

  localparam int LAT = 4 * (2 + 1);

  initial begin
    int         n;
    logic       b;
    logic [3:0] exp_w;
    logic [3:0] old_w;
    int         k;
    logic       c;

    rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0; x = 4'b0000;
    start3 = 1'b0; ready3 = 1'b1; x3 = 4'b0000;
    repeat (3) tick();
    chk("rst_sel", {s2, s1}, 2'b00);
    chk("rst_word", word, 4'b0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_busy", busy, 1'b0);

    // ready with no valid is harmless
    ready = 1'b1;
    repeat (3) tick();
    chk("ready_novalid_valid", valid, 1'b0);
    chk("ready_novalid_busy", busy, 1'b0);

    // SETTLE_CYCLES=3 instance: select sequence and 16-cycle latency
    x3 = 4'b1001; start3 = 1'b1; tick(); start3 = 1'b0;
    chk("sel3_k0", {s2_3, s1_3}, 0);
    for (int kk = 1; kk < 16; kk++) begin
      tick();
      chk($sformatf("sel3_k%0d", kk), {s2_3, s1_3}, kk / 4);
      chk($sformatf("valid3_k%0d", kk), valid3, 1'b0);
    end
    tick();
    chk("valid3_at16", valid3, 1'b1);
    chk("word3", word3, 4'b1001);
    tick();
    chk("valid3_drop", valid3, 1'b0);
    chk("busy3_idle", busy3, 1'b0);

    // single scan, x1..x4 = 1,0,1,1
    x = 4'b1101; cont = 1'b0; ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk("single_busy_accept", busy, 1'b1);
    wait_valid(-1, n, b);
    chk("single_lat", n, LAT);
    chk("single_busy_during", b, 1'b1);
    chk("single_word", word, 4'b1101);
`ifdef MUX_SCAN_PARITY_EN
    chk("single_par", par, 1'b1);
`endif
    tick();
    chk("single_valid_drop", valid, 1'b0);
    chk("single_busy_idle", busy, 1'b0);
    repeat (3) tick();
    chk("single_word_kept", word, 4'b1101);

    // reset mid-SETTLE on channel 2
    x = 4'b0110; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("mid_sel_ch2", {s2, s1}, 2'b10);
    chk("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", {s2, s1}, 2'b00);
    chk("async_rst_word", word, 4'b0000);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
`ifdef MUX_SCAN_PARITY_EN
    chk("async_rst_par", par, 1'b0);
`endif
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_valid", valid, 1'b0);

    // backpressure with an ignored start poke mid-scan
    ready = 1'b0; x = 4'b1011; start = 1'b1; tick(); start = 1'b0;
    wait_valid(4, n, b);
    chk("bp_lat", n, LAT);
    exp_w = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      x = 4'($urandom_range(15, 0));
      tick();
      chk("bp_word", word, exp_w);
      chk("bp_valid", valid, 1'b1);
    end
    ready = 1'b1; tick(); ready = 1'b0;
    chk("bp_accept_drop", valid, 1'b0);
    repeat (4) tick();
    chk("bp_no_queue", busy, 1'b0);

    // continuous: 0000 then 0101, back to back
    x = 4'b0000; cont = 1'b1; ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_valid(5, n, b);
    chk("cont_lat1", n, LAT);
    chk("cont_word1", word, 4'b0000);
    x = 4'b0101;
    tick();
    chk("cont_drop", valid, 1'b0);
    chk("cont_rescan", busy, 1'b1);
    cont = 1'b0;
    wait_valid(3, n, b);
    chk("cont_lat2", n, LAT);
    chk("cont_word2", word, 4'b0101);
`ifdef MUX_SCAN_PARITY_EN
    chk("cont_par2", par, 1'b0);
`endif
    tick();
    chk("cont_end_valid", valid, 1'b0);
    chk("cont_end_busy", busy, 1'b0);

    // randomized scans: word must equal the x pattern present during its scan
    ready = 1'b0;
    x = 4'($urandom_range(15, 0));
    exp_w = x;
    start = 1'b1; tick(); start = 1'b0;
    for (int it = 0; it < 20; it++) begin
      wait_valid(int'($urandom_range(11, 0)), n, b);
      chk("rnd_lat", n, LAT);
      chk("rnd_word", word, exp_w);
`ifdef MUX_SCAN_PARITY_EN
      chk("rnd_par", par, ^exp_w);
`endif
      old_w = exp_w;
      x = 4'($urandom_range(15, 0));
      exp_w = x;
      k = int'($urandom_range(3, 0));
      for (int j = 0; j < k; j++) begin
        tick();
        chk("rnd_hold_word", word, old_w);
      end
      c = 1'($urandom_range(1, 0));
      cont = c; ready = 1'b1; tick(); ready = 1'b0;
      chk("rnd_drop", valid, 1'b0);
      chk("rnd_busy", busy, c);
      if (!c) begin
        start = 1'b1; tick(); start = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
